// File: rtl/mul_share_pkg.sv
// Shared types for the two-lane multiplier arbiter.
// Used by mul_share_rr_arb and mul_share_arbiter.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef logic lane_id_t;

  localparam lane_id_t LANE0 = 1'b0;
  localparam lane_id_t LANE1 = 1'b1;

endpackage

// File: rtl/mul_share_rr_arb.sv
// Two-way round-robin picker.
// On a tie, the lane that did not win last time is granted.
module mul_share_rr_arb
  import mul_share_pkg::*;
(
  input  logic [1:0] i_req,
  input  lane_id_t   i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_gnt,
  output lane_id_t   o_gnt_id
);

  always_comb begin
    o_gnt    = 2'b00;
    o_gnt_id = LANE0;
    if (i_enable) begin
      if (i_req == 2'b11)
        o_gnt_id = ~i_last_grant;
      else if (i_req[1])
        o_gnt_id = LANE1;
      else
        o_gnt_id = LANE0;
      if (|i_req)
        o_gnt = (o_gnt_id == LANE1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One shift-add multiplier shared by two execute lanes.
// Define MUL_SHARE_EARLY_EXIT_EN to finish once the multiplier runs out of set bits.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid0,
  output logic               req_ready0,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic               req_valid1,
  output logic               req_ready1,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               rsp_valid0,
  input  logic               rsp_ready0,
  output logic               rsp_valid1,
  input  logic               rsp_ready1,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy,
  output logic               owner
);

  mul_state_t         r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [CNT_W-1:0]   r_cnt;
  lane_id_t           r_owner;
  lane_id_t           r_last;

  logic [1:0]         w_gnt;
  lane_id_t           w_gnt_id;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic               w_cnt_last;
  logic               w_last;
  logic               w_rsp_rdy;

  mul_share_rr_arb u_arb (
    .i_req        ({req_valid1, req_valid0}),
    .i_last_grant (r_last),
    .i_enable     (r_state == IDLE),
    .o_gnt        (w_gnt),
    .o_gnt_id     (w_gnt_id)
  );

  assign req_ready0 = w_gnt[0];
  assign req_ready1 = w_gnt[1];

  assign w_a = (w_gnt_id == LANE1) ? req_a1 : req_a0;
  assign w_b = (w_gnt_id == LANE1) ? req_b1 : req_b0;

  assign w_acc_nxt  = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
  assign w_b_nxt    = r_b_sh >> 1;
  assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_SHARE_EARLY_EXIT_EN
  assign w_last = w_cnt_last | (w_b_nxt == '0);
`else
  assign w_last = w_cnt_last;
`endif

  // Only the owner's consumer may complete the response.
  assign w_rsp_rdy = (r_owner == LANE1) ? rsp_ready1 : rsp_ready0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
      r_owner <= LANE0;
      r_last  <= LANE1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_a_sh  <= {{WIDTH{1'b0}}, w_a};
            r_b_sh  <= w_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_owner <= w_gnt_id;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc  <= w_acc_nxt;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= w_b_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last)
            r_state <= DONE;
        end
        DONE: begin
          if (w_rsp_rdy) begin
            r_last  <= r_owner;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign owner      = busy & r_owner;
  assign rsp_valid0 = (r_state == DONE) & (r_owner == LANE0);
  assign rsp_valid1 = (r_state == DONE) & (r_owner == LANE1);
  assign rsp_data   = (r_state == DONE) ? r_acc : '0;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter.
// Honors MUL_SHARE_EARLY_EXIT_EN for expected latency.
module tb_mul_share_arbiter;

  localparam int W = 16;
`ifdef MUL_SHARE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
    int             lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid0 = 1'b0;
  logic           req_ready0;
  logic [W-1:0]   req_a0 = '0;
  logic [W-1:0]   req_b0 = '0;
  logic           req_valid1 = 1'b0;
  logic           req_ready1;
  logic [W-1:0]   req_a1 = '0;
  logic [W-1:0]   req_b1 = '0;
  logic           rsp_valid0;
  logic           rsp_ready0 = 1'b1;
  logic           rsp_valid1;
  logic           rsp_ready1 = 1'b1;
  logic [2*W-1:0] rsp_data;
  logic           busy;
  logic           owner;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;

  mul_share_arbiter #(.WIDTH(W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (req_valid0),
    .req_ready0 (req_ready0),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_valid1 (req_valid1),
    .req_ready1 (req_ready1),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid0 (rsp_valid0),
    .rsp_ready0 (rsp_ready0),
    .rsp_valid1 (rsp_valid1),
    .rsp_ready1 (rsp_ready1),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    int m = 0;
    for (int i = 0; i < W; i++)
      if (b[i]) m = i;
    return EARLY ? m + 2 : W + 1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
      pv0 <= 1'b0;
      pv1 <= 1'b0;
    end else begin
      if (rsp_valid0 && !pv0 && q0.size() > 0)
        chk("lat0", 64'(cyc - q0[0].cyc), 64'(q0[0].lat));
      if (rsp_valid1 && !pv1 && q1.size() > 0)
        chk("lat1", 64'(cyc - q1[0].cyc), 64'(q1[0].lat));
      if (rsp_valid0 && rsp_ready0) begin
        if (q0.size() == 0) chk("rsp0_unexp", 1, 0);
        else begin
          e = q0.pop_front();
          chk("rsp0_data", rsp_data, e.prod);
          chk("rsp0_owner", owner, 0);
        end
      end
      if (rsp_valid1 && rsp_ready1) begin
        if (q1.size() == 0) chk("rsp1_unexp", 1, 0);
        else begin
          e = q1.pop_front();
          chk("rsp1_data", rsp_data, e.prod);
          chk("rsp1_owner", owner, 1);
        end
      end
      pv0 <= rsp_valid0;
      pv1 <= rsp_valid1;
    end
  end

  task automatic issue(input bit lane, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit imm);
    int n = 0;
    bit ok = 1'b0;
    exp_t e;
    logic [2*W-1:0] pa, pb;
    @(posedge clk); #1;
    if (lane) begin
      req_valid1 = 1'b1; req_a1 = a; req_b1 = b;
    end else begin
      req_valid0 = 1'b1; req_a0 = a; req_b0 = b;
    end
    if (imm) begin
      #1;
      chk("ready_imm", lane ? req_ready1 : req_ready0, 1);
    end
    while (!ok && n < 400) begin
      @(negedge clk);
      if (lane ? req_ready1 : req_ready0) ok = 1'b1;
      n++;
    end
    if (!ok) chk(lane ? "req1_timeout" : "req0_timeout", 0, 1);
    else begin
      pa = {{W{1'b0}}, a};
      pb = {{W{1'b0}}, b};
      e.prod = pa * pb;
      e.cyc  = cyc;
      e.lat  = exp_lat(b);
      if (lane) q1.push_back(e);
      else q0.push_back(e);
    end
    @(posedge clk); #1;
    if (lane) req_valid1 = 1'b0;
    else req_valid0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (q0.size() == 0 && q1.size() == 0 && !busy), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] d;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_out", {req_ready0, req_ready1, rsp_valid0, rsp_valid1,
                    busy, owner, rsp_data}, 0);
    @(posedge clk); #1 rst = 1'b0;

    issue(0, 16'd3, 16'd5, 1);
    wait_idle();

    do_reset();
    fork
      issue(0, 16'd7, 16'd6, 0);
      issue(1, 16'd9, 16'd9, 0);
    join_none
    repeat (3) @(negedge clk);
    chk("t2_owner0", {busy, owner}, 2'b10);
    repeat (20) @(negedge clk);
    chk("t2_owner1", {busy, owner}, 2'b11);
    wait_idle();

    issue(0, 16'hFFFF, 16'hFFFF, 0);
    issue(0, 16'h0000, 16'h1234, 0);
    issue(1, 16'h1234, 16'h0000, 0);
    wait_idle();

    rsp_ready0 = 1'b0;
    issue(0, 16'd100, 16'd200, 0);
    fork
      issue(1, 16'd5, 16'd6, 0);
    join_none
    n = 0;
    while (!rsp_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid", rsp_valid0, 1);
    d = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold", {rsp_valid0, rsp_data, req_ready1},
          {1'b1, d, 1'b0});
    end
    @(posedge clk); #1 rsp_ready0 = 1'b1;
    wait_idle();

    do_reset();
    issue(0, 16'd5, 16'd7, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_out", {req_ready0, req_ready1, rsp_valid0, rsp_valid1,
                       busy, owner, rsp_data}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_quiet", {rsp_valid0, rsp_valid1, busy}, 0);
    issue(0, 16'd3, 16'd5, 1);
    wait_idle();

    issue(0, 16'd10, 16'd1, 0);
    issue(0, 16'd10, 16'h8000, 0);
    issue(1, 16'd77, 16'd0, 0);
    wait_idle();

    for (int i = 0; i < 4; i++)
      issue(i[0], W'($urandom), W'($urandom), 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
